// File: rtl/md5_cluster_scheduler.sv
// Staggered reset release and round-robin digest collection for a cluster of md5calculator instances.
// Optional build macro MD5_SCHED_STATS_EN adds the run_cycles busy-cycle counter output.
module md5_cluster_scheduler #(
  parameter int unsigned CPU_COUNT = 16,
  parameter int unsigned START_GAP = 4,
  parameter int unsigned ID_W      = (CPU_COUNT > 1) ? $clog2(CPU_COUNT) : 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic [31:0]              data_len,
  output logic [CPU_COUNT-1:0]     cpu_reset,
  output logic [31:0]              cpu_data_len,
  input  logic [CPU_COUNT-1:0]     cpu_done,
  input  logic [128*CPU_COUNT-1:0] cpu_md5,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [127:0]             res_md5,
  output logic [ID_W-1:0]          res_id,
  output logic                     busy,
  output logic                     all_done
`ifdef MD5_SCHED_STATS_EN
  ,
  output logic [31:0]              run_cycles
`endif
);

  localparam int unsigned   GAP_W      = (START_GAP > 1) ? $clog2(START_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(START_GAP - 1);
  localparam logic [ID_W-1:0]  LAST_ID    = ID_W'(CPU_COUNT - 1);
  localparam logic [ID_W:0]    COUNT_EXT  = (ID_W+1)'(CPU_COUNT);

  typedef enum logic [1:0] {IDLE, RELEASE, RUN, DONE} state_t;

  state_t               state;
  logic [CPU_COUNT-1:0] released;
  logic [CPU_COUNT-1:0] acked;
  logic [CPU_COUNT-1:0] pending;
  logic [ID_W-1:0]      rel_idx;
  logic [ID_W-1:0]      rr_ptr;
  logic [ID_W-1:0]      grant;
  logic [ID_W:0]        cand;
  logic [GAP_W-1:0]     gap_cnt;
  logic                 grant_vld;
  logic                 out_free;
  logic                 collecting;
  logic [127:0]         md5_arr [CPU_COUNT];

  for (genvar g = 0; g < CPU_COUNT; g++) begin : g_unpack
    assign md5_arr[g] = cpu_md5[128*g +: 128];
  end

  assign out_free   = !res_valid || res_ready;
  assign collecting = (state == RELEASE) || (state == RUN);
  assign pending    = cpu_done & released & ~acked;

  // Rotating priority: the first pending CPU at or after rr_ptr, wrapping at CPU_COUNT.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    cand      = '0;
    for (int unsigned i = 0; i < CPU_COUNT; i++) begin
      cand = {1'b0, rr_ptr} + (ID_W+1)'(i);
      if (cand >= COUNT_EXT) cand = cand - COUNT_EXT;
      if (!grant_vld && pending[cand[ID_W-1:0]]) begin
        grant_vld = 1'b1;
        grant     = cand[ID_W-1:0];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cpu_reset    <= '1;
      cpu_data_len <= '0;
      res_valid    <= 1'b0;
      res_md5      <= '0;
      res_id       <= '0;
      busy         <= 1'b0;
      all_done     <= 1'b0;
      rr_ptr       <= '0;
      released     <= '0;
      acked        <= '0;
      rel_idx      <= '0;
      gap_cnt      <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state        <= RELEASE;
            busy         <= 1'b1;
            all_done     <= 1'b0;
            cpu_data_len <= data_len;
            released     <= '0;
            acked        <= '0;
            rel_idx      <= '0;
            gap_cnt      <= '0;
          end
        end
        RELEASE: begin
          if (gap_cnt == '0) begin
            released[rel_idx]  <= 1'b1;
            cpu_reset[rel_idx] <= 1'b0;
            gap_cnt            <= GAP_RELOAD;
            if (rel_idx == LAST_ID) state <= RUN;
            else                    rel_idx <= rel_idx + ID_W'(1);
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
        RUN: begin
          if ((&acked) && out_free) begin
            state     <= DONE;
            busy      <= 1'b0;
            all_done  <= 1'b1;
            cpu_reset <= '1;
          end
        end
        default: state <= IDLE;
      endcase

      // Once everything is acked no grant exists, so this also empties the register on DONE entry.
      if (collecting && out_free) begin
        res_valid <= grant_vld;
        if (grant_vld) begin
          res_md5      <= md5_arr[grant];
          res_id       <= grant;
          acked[grant] <= 1'b1;
          rr_ptr       <= (grant == LAST_ID) ? '0 : grant + ID_W'(1);
        end
      end
    end
  end

`ifdef MD5_SCHED_STATS_EN
  logic start_ok;
  assign start_ok = start && ((state == IDLE) || (state == DONE));

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                         run_cycles <= '0;
    else if (start_ok)                 run_cycles <= '0;
    else if (busy && run_cycles != '1) run_cycles <= run_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_md5_cluster_scheduler.sv
// Randomized and directed bench for md5_cluster_scheduler (4 CPUs, gap 4) against a timeline/queue model.
module tb_md5_cluster_scheduler;
  localparam int N   = 4;
  localparam int GAP = 4;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [31:0]      data_len = '0;
  logic [N-1:0]     cpu_reset;
  logic [31:0]      cpu_data_len;
  logic [N-1:0]     cpu_done = '0;
  logic [128*N-1:0] cpu_md5 = '0;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [127:0]     res_md5;
  logic [1:0]       res_id;
  logic             busy;
  logic             all_done;
`ifdef MD5_SCHED_STATS_EN
  logic [31:0]      run_cycles;
  int               busy_cnt = 0;
`endif

  md5_cluster_scheduler #(.CPU_COUNT(N), .START_GAP(GAP)) dut (
    .clock(clock), .reset(reset), .start(start), .data_len(data_len),
    .cpu_reset(cpu_reset), .cpu_data_len(cpu_data_len), .cpu_done(cpu_done),
    .cpu_md5(cpu_md5), .res_valid(res_valid), .res_ready(res_ready),
    .res_md5(res_md5), .res_id(res_id), .busy(busy), .all_done(all_done)
`ifdef MD5_SCHED_STATS_EN
    , .run_cycles(run_cycles)
`endif
  );

  always #5 clock = ~clock;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  bit          cmp_en  = 0;
  int          xfer_cnt [N];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: time since the accepted start decides who is released; results come from a rotating scan.
  bit           m_active, m_done, m_valid;
  int           m_t, m_id, m_rr, mk;
  logic [127:0] m_md5;
  logic [31:0]  m_dlen;
  bit           m_acked [N];
  bit           m_all, m_load;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_active = 0; m_done = 0; m_valid = 0; m_t = 0; m_id = 0; m_rr = 0;
      m_md5 = '0; m_dlen = '0;
      foreach (m_acked[k]) m_acked[k] = 0;
    end else if (!m_active) begin
      if (start) begin
        m_active = 1; m_done = 0; m_t = 0; m_dlen = data_len;
        foreach (m_acked[k]) m_acked[k] = 0;
      end
    end else begin
      m_all = 1;
      foreach (m_acked[k]) m_all &= m_acked[k];
      m_load = !m_valid || res_ready;
      if (m_t > (N-1)*GAP && m_all && m_load) begin
        m_active = 0; m_done = 1; m_valid = 0;
      end else if (m_load) begin
        m_valid = 0;
        for (int i = 0; i < N; i++) begin
          mk = (m_rr + i) % N;
          if (!m_valid && cpu_done[mk] && mk*GAP < m_t && !m_acked[mk]) begin
            m_valid = 1; m_id = mk; m_md5 = cpu_md5[128*mk +: 128];
            m_acked[mk] = 1; m_rr = (mk + 1) % N;
          end
        end
      end
      m_t++;
    end
  end

  logic [N-1:0] exp_rst;
  always @(negedge clock) begin
    if (cmp_en) begin
      exp_rst = '1;
      if (m_active) for (int k = 0; k < N; k++) if (k*GAP < m_t) exp_rst[k] = 1'b0;
      chk("cpu_reset", cpu_reset, exp_rst);
      chk("cpu_data_len", cpu_data_len, m_dlen);
      chk("busy", busy, m_active);
      chk("all_done", all_done, m_done);
      chk("res_valid", res_valid, m_valid);
      if (m_valid) begin
        chk("res_id", res_id, m_id);
        chk("res_md5", res_md5, m_md5);
      end
      if (res_valid && res_ready && !reset) xfer_cnt[res_id]++;
`ifdef MD5_SCHED_STATS_EN
      if (reset) busy_cnt = 0;
      chk("run_cycles", run_cycles, busy_cnt);
      if (m_active) busy_cnt++;
`endif
    end
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic rand_md5();
    for (int k = 0; k < N; k++) cpu_md5[128*k +: 128] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic do_start(input logic [31:0] len);
    foreach (xfer_cnt[k]) xfer_cnt[k] = 0;
    start = 1'b1; data_len = len;
    tick();
    start = 1'b0;
`ifdef MD5_SCHED_STATS_EN
    busy_cnt = 0;
`endif
  endtask

  task automatic wait_done();
    int i;
    for (i = 0; i < 300; i++) begin
      @(negedge clock);
      if (all_done) break;
    end
    if (i == 300) chk("done_timeout", 1'b0, 1'b1);
  endtask

  task automatic check_once();
    for (int k = 0; k < N; k++) chk("reported_once", xfer_cnt[k], 1);
  endtask

  initial begin
    #1 reset = 1'b1;
    #1;
    chk("rst_cpu_reset", cpu_reset, 4'hF);
    chk("rst_data_len", cpu_data_len, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_md5", res_md5, 0);
    chk("rst_res_id", res_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_all_done", all_done, 0);
    cmp_en = 1;
    tick(); tick();
    reset = 1'b0;
    tick();

    // Release staircase, then four simultaneous dones drained back to back.
    rand_md5();
    res_ready = 1'b1;
    do_start(32'd1024);
    for (int t = 0; t <= 13; t++) begin
      @(negedge clock);
      if (t == 0)  begin chk("len_1024", cpu_data_len, 1024); chk("rel_t0", cpu_reset, 4'hF); end
      if (t == 1)  chk("rel_t1", cpu_reset, 4'hE);
      if (t == 4)  chk("rel_t4", cpu_reset, 4'hE);
      if (t == 5)  chk("rel_t5", cpu_reset, 4'hC);
      if (t == 9)  chk("rel_t9", cpu_reset, 4'h8);
      if (t == 13) begin chk("rel_t13", cpu_reset, 4'h0); chk("busy_t13", busy, 1); end
      @(posedge clock); #1;
    end
    cpu_done = '1;
    for (int j = 14; j <= 19; j++) begin
      @(negedge clock);
      if (j >= 15 && j <= 18) begin
        chk("b2b_valid", res_valid, 1);
        chk("b2b_id", res_id, j - 15);
      end
      if (j == 19) begin
        chk("end_all_done", all_done, 1);
        chk("end_cpu_reset", cpu_reset, 4'hF);
        chk("end_valid", res_valid, 0);
      end
    end
    tick();
    cpu_done = '0;
    check_once();

    // Early done on every CPU while the consumer stalls for ten cycles.
    rand_md5();
    res_ready = 1'b0;
    do_start($urandom);
    cpu_done = '1;
    for (int t = 0; t <= 11; t++) begin
      @(negedge clock);
      chk("no_id3_early", res_valid && res_id == 2'd3, 1'b0);
      if (t >= 2) begin
        chk("stall_valid", res_valid, 1);
        chk("stall_id", res_id, 0);
        chk("stall_md5", res_md5, cpu_md5[127:0]);
      end
      @(posedge clock); #1;
    end
    res_ready = 1'b1;
    wait_done();
    tick();
    cpu_done = '0;
    check_once();

    // Random runs; one is abandoned by an asynchronous reset while a result is held.
    for (int r = 0; r < 6; r++) begin
      rand_md5();
      do_start($urandom);
      if (r == 2) begin
        for (int c = 0; c < 14; c++) tick();
        cpu_done = '1; res_ready = 1'b0;
        tick(); tick(); tick();
        @(negedge clock);
        chk("held_before_reset", res_valid, 1);
        #2 reset = 1'b1;
        #1;
        chk("abort_valid", res_valid, 0);
        chk("abort_cpu_reset", cpu_reset, 4'hF);
        chk("abort_busy", busy, 0);
        @(posedge clock); #1;
        reset = 1'b0; cpu_done = '0;
        tick();
      end else begin
        int c;
        for (c = 0; c < 400 && !all_done; c++) begin
          for (int k = 0; k < N; k++) if ($urandom_range(0, 5) == 0) cpu_done[k] = 1'b1;
          res_ready = ($urandom_range(0, 3) != 0);
          if (busy && $urandom_range(0, 15) == 0) begin start = 1'b1; data_len = $urandom; end
          else start = 1'b0;
          tick();
        end
        start = 1'b0;
        if (c == 400) chk("rand_timeout", 1'b0, 1'b1);
        tick(); tick();
        cpu_done = '0;
        check_once();
      end
    end

    tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/md5_cluster_scheduler.md
MD5_CLUSTER_SCHEDULER -- requirements
Module: md5_cluster_scheduler

Interface
REQ-001 Parameter CPU_COUNT, default 16, number of md5calculator instances managed (1..1024).
REQ-002 Parameter START_GAP, default 4, cycles between successive per-CPU reset releases (>=1).
REQ-003 Parameter ID_W, default $clog2(CPU_COUNT) min 1, width of result index.
REQ-004 clock  in  1  sole clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-high; one clock, no other reset source.
REQ-006 start  in  1  single-cycle run request; honoured only in IDLE or DONE.
REQ-007 data_len  in  32  message length, latched on accepted start.
REQ-008 cpu_reset  out  CPU_COUNT  per-CPU reset to md5calculator, 1 = held in reset.
REQ-009 cpu_data_len  out  32  latched data_len, common to all CPUs.
REQ-010 cpu_done  in  CPU_COUNT  per-CPU done level.
REQ-011 cpu_md5  in  128*CPU_COUNT  flattened digests, CPU n at bits [128n+127:128n].
REQ-012 res_valid/res_ready  out/in  1/1  result handshake; transfer when both high on a clock edge.
REQ-013 res_md5  out  128  digest of transferring result; res_id out ID_W, its CPU index.
REQ-014 busy  out  1  high in RELEASE and RUN; all_done out 1, high in DONE.

Function
REQ-015 FSM states IDLE, RELEASE, RUN, DONE; a start accepted in IDLE or DONE shall latch data_len, clear released/acked vectors, zero release index and gap counter, enter RELEASE next cycle.
REQ-016 RELEASE: cpu_reset[k] shall deassert for k = 0,1,..., CPU_COUNT-1 in index order; CPU 0 released on the first RELEASE cycle, each next exactly START_GAP cycles later.
REQ-017 RELEASE -> RUN on the cycle after the last CPU is released.
REQ-018 pending[n] = cpu_done[n] & released[n] & ~acked[n]; unreleased CPUs' done shall be ignored.
REQ-019 Output register (res_valid, res_md5, res_id) shall load when empty or transferring this cycle; back-to-back results at one per cycle.
REQ-020 Grant: round-robin among pending, search starting at rr_ptr; on load set acked[grant] and rr_ptr = grant+1 modulo CPU_COUNT (wraps to 0).
REQ-021 res_md5/res_id shall stay stable while res_valid & ~res_ready.
REQ-022 Collection shall run in both RELEASE and RUN.
REQ-023 RUN -> DONE when acked is all ones and the output register is empty or transferring this cycle.
REQ-024 DONE: all cpu_reset bits reasserted, all_done = 1, res_valid = 0 until next start.
REQ-025 start while busy shall be ignored.
REQ-026 CPU_COUNT = 1: single release, rr_ptr constant 0.

Reset
REQ-027 On reset assertion (async): state IDLE, cpu_reset all ones, cpu_data_len 0, res_valid 0, res_md5 0, res_id 0, busy 0, all_done 0, rr_ptr 0, released/acked 0, counters 0.
REQ-028 Reset mid-run shall abandon the run, discard any held result, and reassert all cpu_reset immediately.

Configuration
REQ-029 Macro MD5_SCHED_STATS_EN defined: extra output run_cycles (32), zeroed on accepted start, +1 each busy cycle, saturating at 0xFFFFFFFF, frozen in DONE, reset to 0.
REQ-030 Macro undefined: no run_cycles port and no counter logic; all other behaviour identical.

Verification
REQ-031 CPU_COUNT=4, START_GAP=4, start with data_len=1024 -> cpu_reset bits drop at RELEASE cycles 0,4,8,12; cpu_data_len=1024.
REQ-032 All four cpu_done high same cycle, res_ready=1 -> res_id 0,1,2,3 on consecutive cycles, then all_done=1, cpu_reset=4'hF.
REQ-033 res_ready=0 for 10 cycles with valid result -> res_md5/res_id unchanged, no loss; each CPU reported exactly once.
REQ-034 cpu_done[3] high before CPU 3 released -> no result for id 3 until released.
REQ-035 Reset asserted during RUN with res_valid=1 -> res_valid=0 and cpu_reset all ones same cycle; new start runs cleanly.
REQ-036 MD5_SCHED_STATS_EN, CPU_COUNT=2, START_GAP=1, dones at RUN cycle 0, res_ready=1 -> run_cycles equals busy-cycle count, frozen in DONE.
